// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Arbitrates an instruction-fetch port and a data port onto one shared
// single-port memory. One transaction is in flight at a time. Simultaneous
// requests alternate between ports. A misaligned data access is rejected
// locally with an error response. An access the memory never acknowledges
// is aborted after TIMEOUT cycles. Every output comes straight from a flop.

module mem_port_arbiter #(
   parameter int unsigned TIMEOUT = 255   // legal range 1..1023
) (
   input  logic        clk,
   input  logic        reset,

   // instruction-fetch port (read only)
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_gnt,
   output logic        i_rvalid,
   output logic [31:0] i_rdata,
   output logic        i_err,

   // data port (load / store)
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_be,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic        d_err,

   // shared memory
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2,
      ERR_D  = 2'd3
   } state_e;

   // Port that received the most recent grant; used to break ties.
   typedef enum logic {
      PORT_I = 1'b0,
      PORT_D = 1'b1
   } port_e;

   localparam logic [9:0] TIMEOUT_CNT = 10'(TIMEOUT);

   // Word-alignment mask. Masking keeps every address bit in use.
   localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

   state_e      state_q, state_d;
   port_e       last_grant_q, last_grant_d;
   logic [9:0]  cnt_q, cnt_d;

   logic        i_gnt_q, i_gnt_d;
   logic        i_rvalid_q, i_rvalid_d;
   logic [31:0] i_rdata_q, i_rdata_d;
   logic        i_err_q, i_err_d;

   logic        d_gnt_q, d_gnt_d;
   logic        d_rvalid_q, d_rvalid_d;
   logic [31:0] d_rdata_q, d_rdata_d;
   logic        d_err_q, d_err_d;

   logic        mem_req_q, mem_req_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [3:0]  mem_be_q, mem_be_d;

   logic        pick_i;
   logic        pick_d;
   logic        d_be_ok;
   logic        ack_seen;
   logic [9:0]  cnt_inc;

   // Arbitration and access checks for the current request inputs
   always_comb begin
      // Fetch wins a tie only when data went last.
      pick_i   = i_req && (!d_req || (last_grant_q == PORT_D));
      pick_d   = d_req && !pick_i;
      // Enabled bytes must lie at or above the byte offset of d_addr.
      d_be_ok  = ((d_be & ~(4'hF << d_addr[1:0])) == 4'h0);
      // mem_ack only counts while a request is actually outstanding.
      ack_seen = mem_ack && mem_req_q;
      cnt_inc  = cnt_q + 10'd1;
   end

   // Next-state and next-output logic
   always_comb begin
      // NOTE: every signal assigned below gets a default first, so no path
      // leaves one unassigned and no latch is inferred.
      state_d      = state_q;
      last_grant_d = last_grant_q;
      cnt_d        = cnt_q;

      i_gnt_d      = 1'b0;
      i_rvalid_d   = 1'b0;
      i_rdata_d    = 32'h0;
      i_err_d      = 1'b0;
      d_gnt_d      = 1'b0;
      d_rvalid_d   = 1'b0;
      d_rdata_d    = 32'h0;
      d_err_d      = 1'b0;

      // The memory request fields hold their value unless a grant reloads them.
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      mem_be_d     = mem_be_q;

      unique case (state_q)
         IDLE: begin
            if (pick_i) begin
               state_d      = BUSY_I;
               last_grant_d = PORT_I;
               cnt_d        = 10'd0;
               i_gnt_d      = 1'b1;
               mem_req_d    = 1'b1;
               mem_we_d     = 1'b0;
               mem_addr_d   = i_addr & WORD_MASK;
               mem_wdata_d  = 32'h0;
               mem_be_d     = 4'hF;
            end else if (pick_d) begin
               last_grant_d = PORT_D;
               d_gnt_d      = 1'b1;
               if (d_be_ok) begin
                  state_d     = BUSY_D;
                  cnt_d       = 10'd0;
                  mem_req_d   = 1'b1;
                  mem_we_d    = d_we;
                  mem_addr_d  = d_addr & WORD_MASK;
                  mem_wdata_d = d_wdata;
                  mem_be_d    = d_be;
               end else begin
                  // Rejected without touching memory; error reply follows.
                  state_d = ERR_D;
               end
            end
         end

         BUSY_I, BUSY_D: begin
            if (!ack_seen) begin
               cnt_d = cnt_inc;
            end
            // An ack in the cycle the timeout is reached still completes normally.
            if (ack_seen || (cnt_inc == TIMEOUT_CNT)) begin
               state_d   = IDLE;
               mem_req_d = 1'b0;
               if (state_q == BUSY_D) begin
                  d_rvalid_d = 1'b1;
                  d_rdata_d  = ack_seen ? mem_rdata : 32'h0;
                  d_err_d    = !ack_seen;
               end else begin
                  i_rvalid_d = 1'b1;
                  i_rdata_d  = ack_seen ? mem_rdata : 32'h0;
                  i_err_d    = !ack_seen;
               end
            end
         end

         ERR_D: begin
            state_d    = IDLE;
            d_rvalid_d = 1'b1;
            d_err_d    = 1'b1;
            d_rdata_d  = 32'h0;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; reset drops any in-flight transaction
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: state and output flops all have a reset value, so the outputs
      // go to 0 as soon as reset is asserted. No trace of an interrupted
      // access survives reset.
      if (reset) begin
         state_q      <= IDLE;
         last_grant_q <= PORT_D;
         cnt_q        <= 10'd0;
         i_gnt_q      <= 1'b0;
         i_rvalid_q   <= 1'b0;
         i_rdata_q    <= 32'h0;
         i_err_q      <= 1'b0;
         d_gnt_q      <= 1'b0;
         d_rvalid_q   <= 1'b0;
         d_rdata_q    <= 32'h0;
         d_err_q      <= 1'b0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= 32'h0;
         mem_wdata_q  <= 32'h0;
         mem_be_q     <= 4'h0;
      end else begin
         // NOTE: non-blocking assignments, so every flop sees the values
         // from before this clock edge. Evaluation order does not matter.
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         cnt_q        <= cnt_d;
         i_gnt_q      <= i_gnt_d;
         i_rvalid_q   <= i_rvalid_d;
         i_rdata_q    <= i_rdata_d;
         i_err_q      <= i_err_d;
         d_gnt_q      <= d_gnt_d;
         d_rvalid_q   <= d_rvalid_d;
         d_rdata_q    <= d_rdata_d;
         d_err_q      <= d_err_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_be_q     <= mem_be_d;
      end
   end

   assign i_gnt     = i_gnt_q;
   assign i_rvalid  = i_rvalid_q;
   assign i_rdata   = i_rdata_q;
   assign i_err     = i_err_q;
   assign d_gnt     = d_gnt_q;
   assign d_rvalid  = d_rvalid_q;
   assign d_rdata   = d_rdata_q;
   assign d_err     = d_err_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_be    = mem_be_q;

endmodule
